// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT output reorder stage.
//   DATA_WIDTH_DEF / N_POINTS_DEF : default component width and frame length
//   rd_state_e                    : read-side FSM states
//   bitrev()                      : reverse the low nbits of an index
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int N_POINTS_DEF   = 16;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_e;

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      r[i] = idx[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_dpram.sv
// fft_dpram: simple dual-port RAM, synchronous write, registered read.
//   clk      : clock
//   we       : write enable
//   wr_addr  : write address {bank, index}
//   wr_data  : write data
//   rd_en    : read enable; rd_data holds when low
//   rd_addr  : read address {bank, index}
//   rd_data  : read data, valid the cycle after rd_en
// Contents are deliberately not reset.
module fft_dpram #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: buffers bit-reversed FFT frames in a ping-pong RAM and
// replays each frame in natural order with frame-boundary markers.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : din_* valid this cycle
//   din_re/im  : FFT output sample, bit-reversed order
//   dout_re/im : reordered sample (holds when dout_valid=0)
//   dout_valid : dout_* valid
//   dout_first : natural index 0 of a frame
//   dout_last  : natural index N-1 of a frame
//
// Read FSM
//   state  | meaning
//   R_IDLE | no frame pending, RAM read disabled
//   R_READ | sweeping rd_bank addresses 0..N-1, one per cycle
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_POINTS   = N_POINTS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din_re,
  input  logic [DATA_WIDTH-1:0] din_im,
  output logic [DATA_WIDTH-1:0] dout_re,
  output logic [DATA_WIDTH-1:0] dout_im,
  output logic                  dout_valid,
  output logic                  dout_first,
  output logic                  dout_last
);

  localparam int LOG2N_BITS = $clog2(N_POINTS);
  localparam logic [LOG2N_BITS-1:0] CNT_MAX = LOG2N_BITS'(N_POINTS - 1);

  logic [LOG2N_BITS-1:0]   wr_cnt_q;
  logic                    wr_bank_q;
  logic [LOG2N_BITS-1:0]   wr_idx;
  logic                    frame_done;

  rd_state_e               state_q, state_d;
  logic [LOG2N_BITS-1:0]   rd_cnt_q, rd_cnt_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    rd_en;

  logic                    s1_valid, s1_first, s1_last;
  logic [2*DATA_WIDTH-1:0] ram_q;

  // Combinational so the reader starts on the same edge that stores the
  // final sample; this gives the two-cycle capture-to-X[0] latency.
  assign frame_done = en && (wr_cnt_q == CNT_MAX);
  assign wr_idx     = LOG2N_BITS'(bitrev(32'(wr_cnt_q), LOG2N_BITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (en) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
      if (frame_done) begin
        wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= R_IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = frame_done ? wr_bank_q : rd_bank_q;
    rd_en     = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (frame_done) begin
          state_d  = R_READ;
          rd_cnt_d = '0;
        end
      end
      R_READ: begin
        rd_en = 1'b1;
        if (rd_cnt_q == CNT_MAX) begin
          rd_cnt_d = '0;
          if (!frame_done) begin
            state_d = R_IDLE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  fft_dpram #(
    .WIDTH     (2*DATA_WIDTH),
    .ADDR_BITS (LOG2N_BITS+1)
  ) u_ram (
    .clk     (clk),
    .we      (en),
    .wr_addr ({wr_bank_q, wr_idx}),
    .wr_data ({din_re, din_im}),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank_q, rd_cnt_q}),
    .rd_data (ram_q)
  );

  // Markers travel one stage alongside the registered RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      s1_first <= rd_en && (rd_cnt_q == '0);
      s1_last  <= rd_en && (rd_cnt_q == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_re    <= '0;
      dout_im    <= '0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= s1_valid;
      dout_first <= s1_first;
      dout_last  <= s1_last;
      if (s1_valid) begin
        {dout_re, dout_im} <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int N  = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din_re, din_im;
  logic [DW-1:0] dout_re, dout_im;
  logic          dout_valid, dout_first, dout_last;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din_re     (din_re),
    .din_im     (din_im),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_first (dout_first),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            idx;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            kcnt = 0;
  int            outs_total = 0;
  logic [DW-1:0] cap_re [N];
  logic [DW-1:0] cap_im [N];
  exp_t          exp_q[$];
  int            lastins[$];
  int            firsts[$];
  logic [DW-1:0] seen_re[$];
  logic [DW-1:0] seen_im[$];
  bit            capture_on = 0;
  logic [DW-1:0] last_re = '0;
  logic [DW-1:0] last_im = '0;

  function automatic int br4(input int k);
    logic [3:0] v;
    v = 4'(k);
    return int'({v[0], v[1], v[2], v[3]});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: collect a frame as delivered, then schedule the natural
  // order X[n] = sample at input position bitrev(n), starting 2 edges later.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      kcnt = 0;
      exp_q.delete();
    end else if (en) begin
      cap_re[kcnt] = din_re;
      cap_im[kcnt] = din_im;
      kcnt++;
      if (kcnt == N) begin
        lastins.push_back(cyc);
        for (int n = 0; n < N; n++) begin
          exp_q.push_back('{due: cyc + 2 + n, re: cap_re[br4(n)],
                            im: cap_im[br4(n)], idx: n});
        end
        kcnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      check("reset_outputs", 64'({dout_valid, dout_first, dout_last, dout_re, dout_im}), 64'(0));
      last_re = '0;
      last_im = '0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("dout", 64'({dout_valid, dout_first, dout_last, dout_re, dout_im}),
            64'({1'b1, e.idx == 0, e.idx == N-1, e.re, e.im}));
      last_re = e.re;
      last_im = e.im;
      outs_total++;
      if (dout_first) firsts.push_back(cyc);
      if (capture_on) begin
        seen_re.push_back(dout_re);
        seen_im.push_back(dout_im);
      end
    end else begin
      check("idle_hold", 64'({dout_valid, dout_first, dout_last, dout_re, dout_im}),
            64'({3'b000, last_re, last_im}));
    end
  end

  task automatic drive(input logic [DW-1:0] re, input logic [DW-1:0] im);
    en     = 1'b1;
    din_re = re;
    din_im = im;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    din_re = DW'($urandom);
    din_im = DW'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    lastins.delete();
    firsts.delete();
    seen_re.delete();
    seen_im.delete();
  endtask

  task automatic random_frame(input int gap_pct);
    int k;
    k = 0;
    while (k < N) begin
      if ($urandom_range(0, 99) < gap_pct) idle(1);
      else begin
        drive(DW'($urandom), DW'($urandom));
        k++;
      end
    end
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_count"}, 64'(seen_re.size()), 64'(N));
    for (int n = 0; n < N && n < seen_re.size(); n++) begin
      check({tag, "_re"}, 64'(seen_re[n]), 64'(n));
      check({tag, "_im"}, 64'(seen_im[n]), 64'(16'hFFFF - 16'(n)));
    end
    check({tag, "_nfirst"}, 64'(firsts.size()), 64'(1));
    if (firsts.size() > 0 && lastins.size() > 0)
      check({tag, "_latency"}, 64'(firsts[0] - lastins[0]), 64'(2));
  endtask

  initial begin
    int base;
    rst = 1'b1; en = 1'b0; din_re = '0; din_im = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // single ramp frame
    clear_logs(); capture_on = 1;
    for (int k = 0; k < N; k++) drive(DW'(br4(k)), ~DW'(br4(k)));
    idle(24); capture_on = 0;
    check_ramp("single");

    // three back-to-back frames
    clear_logs();
    for (int k = 0; k < 3*N; k++) drive(DW'($urandom), DW'($urandom));
    idle(24);
    check("b2b_nfirst", 64'(firsts.size()), 64'(3));
    for (int i = 0; i < 3 && i < firsts.size() && lastins.size() > 0; i++)
      check("b2b_first_cyc", 64'(firsts[i] - lastins[0]), 64'(2 + 16*i));

    // gapped ramp frame: en 1,0,1,0,...
    clear_logs(); capture_on = 1;
    for (int k = 0; k < N; k++) begin
      drive(DW'(br4(k)), ~DW'(br4(k)));
      idle(1);
    end
    idle(24); capture_on = 0;
    check_ramp("gapped");

    // reset mid-frame, then a full frame
    for (int k = 0; k < 7; k++) drive(DW'($urandom), DW'($urandom));
    en = 1'b0; rst = 1'b1;
    #1 check("rst_midframe", 64'({dout_valid, dout_re, dout_im}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);
    random_frame(0);
    idle(24);

    // reset at the 5th output of a readout
    random_frame(0);
    en = 1'b0;
    base = outs_total;
    for (int i = 0; i < 40 && outs_total < base + 5; i++) @(negedge clk);
    check("rdout_wait", 64'(outs_total), 64'(base + 5));
    rst = 1'b1;
    #1 check("rst_readout", 64'({dout_valid, dout_first, dout_last, dout_re, dout_im}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(24);
    random_frame(0);
    idle(24);

    // extremes
    clear_logs(); capture_on = 1;
    for (int k = 0; k < N; k++)
      drive((k % 2 == 0) ? 16'h8000 : 16'h7FFF, (k % 2 == 0) ? 16'h7FFF : 16'h8000);
    idle(24); capture_on = 0;
    check("ext_count", 64'(seen_re.size()), 64'(N));
    for (int n = 0; n < N && n < seen_re.size(); n++) begin
      check("ext_re", 64'(seen_re[n]), 64'((n < 8) ? 16'h8000 : 16'h7FFF));
      check("ext_im", 64'(seen_im[n]), 64'((n < 8) ? 16'h7FFF : 16'h8000));
    end

    // randomized frames with random gaps and spacing
    for (int f = 0; f < 8; f++) begin
      random_frame($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20));
    end
    idle(40);
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
